// File: rtl/stream_router_if.sv
// rtl/stream_router_if.sv - handshake bundle between a merged input stream and N routed output streams
//
// Purpose: groups the input beat (data/qos/id/last/valid/ready) and the per-output
// beat signals of stream_router so they travel as one port.
// Ports (signal names are from the router's point of view):
//   s_data_i, s_qos_i, s_id_i, s_last_i, s_valid_i  input beat
//   s_ready_o                                       input ready (registered in the router)
//   m_data_o, m_qos_o, m_last_o, m_valid_o          per-output beat
//   m_ready_i                                       per-output ready
// Modports: slave = router side, master = traffic source/sink side.
interface stream_router_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2
);
  localparam int T_ID___WIDTH = $clog2(STREAM_COUNT);

  logic [T_DATA_WIDTH-1:0]                    s_data_i;
  logic [T_QOS__WIDTH-1:0]                    s_qos_i;
  logic [T_ID___WIDTH-1:0]                    s_id_i;
  logic                                       s_last_i;
  logic                                       s_valid_i;
  logic                                       s_ready_o;

  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_o;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_o;
  logic [STREAM_COUNT-1:0]                    m_last_o;
  logic [STREAM_COUNT-1:0]                    m_valid_o;
  logic [STREAM_COUNT-1:0]                    m_ready_i;

  modport slave (
    input  s_data_i, s_qos_i, s_id_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_qos_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_qos_i, s_id_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_qos_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_router.sv
// rtl/stream_router.sv - packet-aware 1-to-N stream demultiplexer with 2-entry input skid buffer
//
// Purpose: routes each packet of the merged input stream to output s_id_i (taken from
// the first beat), holds that route until the last beat, and discards packets whose id
// has no matching output while counting them.
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bus         stream_router_if.slave: input beat + per-output beats
//   drop_cnt_o  saturating count of dropped packets
module stream_router #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_router_if.slave        bus,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);
  localparam int T_ID___WIDTH = $clog2(STREAM_COUNT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  // One extra bit so ids up to 2**T_ID___WIDTH-1 can be compared against STREAM_COUNT.
  localparam logic [T_ID___WIDTH:0] N_EXT = (T_ID___WIDTH+1)'(STREAM_COUNT);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_QOS__WIDTH-1:0] qos;
    logic [T_ID___WIDTH-1:0] id;
    logic                    last;
  } entry_t;

  entry_t                  mem_q [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              cnt_q, cnt_d;
  logic                    s_ready_q, s_ready_d;
  logic [1:0]              state_q, state_d;
  logic [T_ID___WIDTH-1:0] lock_id_q, lock_id_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  entry_t                  head;
  logic                    head_valid;
  logic [T_ID___WIDTH-1:0] dest;
  logic [T_ID___WIDTH:0]   dest_ext;
  logic                    routable;
  logic                    sel_valid;
  logic                    hs;
  logic                    drop_now;
  logic                    push, pop;
  entry_t                  entry_in;

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (cnt_q != 2'd0);

  // The id on the head beat only matters while no packet is in flight.
  assign dest      = (state_q == S_IDLE) ? head.id : lock_id_q;
  assign dest_ext  = {1'b0, dest};
  assign routable  = (dest_ext < N_EXT);
  assign sel_valid = head_valid && (state_q != S_DROP) && routable;

  for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_out
    assign bus.m_data_o[i]  = head.data;
    assign bus.m_qos_o[i]   = head.qos;
    assign bus.m_last_o[i]  = head.last;
    assign bus.m_valid_o[i] = sel_valid && (dest_ext == (T_ID___WIDTH+1)'(i));
  end

  // Only the selected output can have valid set, so ready elsewhere drops out here.
  assign hs       = |(bus.m_valid_o & bus.m_ready_i);
  assign drop_now = head_valid && (state_q == S_IDLE) && !routable;
  assign push     = bus.s_valid_i && s_ready_q;
  assign pop      = hs || drop_now || (head_valid && (state_q == S_DROP));

  assign entry_in = '{data: bus.s_data_i, qos: bus.s_qos_i, id: bus.s_id_i, last: bus.s_last_i};

  assign bus.s_ready_o = s_ready_q;
  assign drop_cnt_o    = drop_cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    // Registered ready: next cycle may accept only if a slot will be free.
    s_ready_d = (cnt_d < 2'd2);
  end

  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (drop_now) begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
          if (!head.last) state_d = S_DROP;
        end else if (hs && !head.last) begin
          lock_id_d = head.id;
          state_d   = S_FWD;
        end
      end
      S_FWD: begin
        if (hs && head.last) state_d = S_IDLE;
      end
      S_DROP: begin
        if (head_valid && head.last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      s_ready_q  <= 1'b0;
      state_q    <= S_IDLE;
      lock_id_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end
endmodule

// File: tb/tb_stream_router.sv
// tb/tb_stream_router.sv - self-checking bench for stream_router (N=2 and N=3 instances)
module tb_stream_router;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_router_if #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(2)) ifa ();
  stream_router_if #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(3)) ifb ();
  logic [7:0] drop_a;
  logic [1:0] drop_b;

  stream_router #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(2), .DROP_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .drop_cnt_o(drop_a));
  stream_router #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(3), .DROP_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .drop_cnt_o(drop_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] qos_of(input int d);
    return 4'(d * 7 + 3);
  endfunction

  // Packet-level model: each accepted packet either lands whole, in order, on its
  // first-beat id, or (id out of range) vanishes and bumps a saturating counter.
  typedef struct {int port; int data; int qos; int last;} beat_t;
  beat_t exp_a[$];
  beat_t exp_b[$];
  beat_t ea, eb;
  int    out_a[3], out_b[3];
  bit    inpkt_a, inpkt_b;
  int    dest_a, dest_b;
  int    drops_a, drops_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a.delete(); inpkt_a = 0; drops_a = 0;
    end else begin
      if (ifa.m_valid_o != '0) begin
        check("a_onehot", 32'($onehot(ifa.m_valid_o)), 1);
        if (exp_a.size() == 0) check("a_unexpected_valid", 32'(ifa.m_valid_o), 0);
        else begin
          ea = exp_a[0];
          check("a_port", 32'(ifa.m_valid_o), 1 << ea.port);
          check("a_data", 32'(ifa.m_data_o[ea.port]), ea.data);
          check("a_qos", 32'(ifa.m_qos_o[ea.port]), ea.qos);
          check("a_last", 32'(ifa.m_last_o[ea.port]), ea.last);
          if ((ifa.m_valid_o & ifa.m_ready_i) != '0) begin
            void'(exp_a.pop_front());
            out_a[ea.port]++;
          end
        end
      end
      if (ifa.s_valid_i && ifa.s_ready_o) begin
        if (!inpkt_a) begin
          dest_a = int'(ifa.s_id_i);
          if (dest_a >= 2 && drops_a < 255) drops_a++;
        end
        if (dest_a < 2)
          exp_a.push_back('{dest_a, int'(ifa.s_data_i), int'(ifa.s_qos_i), int'(ifa.s_last_i)});
        inpkt_a = !ifa.s_last_i;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b.delete(); inpkt_b = 0; drops_b = 0;
    end else begin
      if (ifb.m_valid_o != '0) begin
        check("b_onehot", 32'($onehot(ifb.m_valid_o)), 1);
        if (exp_b.size() == 0) check("b_unexpected_valid", 32'(ifb.m_valid_o), 0);
        else begin
          eb = exp_b[0];
          check("b_port", 32'(ifb.m_valid_o), 1 << eb.port);
          check("b_data", 32'(ifb.m_data_o[eb.port]), eb.data);
          check("b_qos", 32'(ifb.m_qos_o[eb.port]), eb.qos);
          check("b_last", 32'(ifb.m_last_o[eb.port]), eb.last);
          if ((ifb.m_valid_o & ifb.m_ready_i) != '0) begin
            void'(exp_b.pop_front());
            out_b[eb.port]++;
          end
        end
      end
      if (ifb.s_valid_i && ifb.s_ready_o) begin
        if (!inpkt_b) begin
          dest_b = int'(ifb.s_id_i);
          if (dest_b >= 3 && drops_b < 3) drops_b++;
        end
        if (dest_b < 3)
          exp_b.push_back('{dest_b, int'(ifb.s_data_i), int'(ifb.s_qos_i), int'(ifb.s_last_i)});
        inpkt_b = !ifb.s_last_i;
      end
    end
  end

  task automatic a_drive(input int id, input int data, input int last);
    ifa.s_valid_i = 1'b1;
    ifa.s_id_i    = 1'(id);
    ifa.s_data_i  = 8'(data);
    ifa.s_qos_i   = qos_of(data);
    ifa.s_last_i  = 1'(last);
  endtask

  task automatic b_drive(input int id, input int data, input int last);
    ifb.s_valid_i = 1'b1;
    ifb.s_id_i    = 2'(id);
    ifb.s_data_i  = 8'(data);
    ifb.s_qos_i   = qos_of(data);
    ifb.s_last_i  = 1'(last);
  endtask

  // Offer a beat and return #1 after the edge that accepted it.
  task automatic a_send(input int id, input int data, input int last);
    bit ok = 0;
    a_drive(id, data, last);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (ifa.s_ready_o) ok = 1;
    end
    if (!ok) check("a_send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic b_send(input int id, input int data, input int last);
    bit ok = 0;
    b_drive(id, data, last);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (ifb.s_ready_o) ok = 1;
    end
    if (!ok) check("b_send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic a_drain();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (exp_a.size() == 0 && ifa.m_valid_o == '0) break;
    end
    check("a_drain_left", exp_a.size(), 0);
  endtask

  task automatic b_drain();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (exp_b.size() == 0 && ifb.m_valid_o == '0) break;
    end
    check("b_drain_left", exp_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base0, base1, base2;
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0;
    ifa.s_valid_i = 1'b0; ifa.s_id_i = '0; ifa.s_data_i = '0; ifa.s_qos_i = '0; ifa.s_last_i = 1'b0;
    ifb.s_valid_i = 1'b0; ifb.s_id_i = '0; ifb.s_data_i = '0; ifb.s_qos_i = '0; ifb.s_last_i = 1'b0;
    ifa.m_ready_i = '0;
    ifb.m_ready_i = '0;

    // Reset: 3 clocks low, then ready rises one edge after release.
    repeat (3) begin
      @(negedge clk);
      check("rst_a_ready", 32'(ifa.s_ready_o), 0);
      check("rst_b_ready", 32'(ifb.s_ready_o), 0);
      check("rst_a_valid", 32'(ifa.m_valid_o), 0);
      check("rst_a_drop", 32'(drop_a), 0);
      check("rst_b_drop", 32'(drop_b), 0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("rel_a_ready_before_edge", 32'(ifa.s_ready_o), 0);
    @(negedge clk);
    check("rel_a_ready", 32'(ifa.s_ready_o), 1);
    check("rel_b_ready", 32'(ifb.s_ready_o), 1);
    check("rel_a_valid", 32'(ifa.m_valid_o), 0);

    // 3-beat packet to output 1, full throughput, 1-cycle latency.
    ifa.m_ready_i = 2'b11;
    @(posedge clk); #1;
    a_drive(1, 8'hA1, 0);
    @(negedge clk); check("t1_ready", 32'(ifa.s_ready_o), 1);
    @(posedge clk); #1; a_drive(1, 8'hA2, 0);
    @(negedge clk);
    check("t1_v0", 32'(ifa.m_valid_o), 2);
    check("t1_d0", 32'(ifa.m_data_o[1]), 32'h A1);
    @(posedge clk); #1; a_drive(1, 8'hA3, 1);
    @(negedge clk);
    check("t1_v1", 32'(ifa.m_valid_o), 2);
    check("t1_d1", 32'(ifa.m_data_o[1]), 32'h A2);
    check("t1_nolast1", 32'(ifa.m_last_o[1]), 0);
    @(posedge clk); #1; ifa.s_valid_i = 1'b0;
    @(negedge clk);
    check("t1_v2", 32'(ifa.m_valid_o), 2);
    check("t1_d2", 32'(ifa.m_data_o[1]), 32'h A3);
    check("t1_last", 32'(ifa.m_last_o[1]), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_idle", 32'(ifa.m_valid_o), 0);

    // Route lock: 2nd beat's id is ignored; next packet follows its own id.
    base0 = out_a[0]; base1 = out_a[1];
    @(posedge clk); #1;
    a_send(0, 8'hB1, 0);
    a_send(1, 8'hB2, 1);
    a_send(1, 8'hC1, 1);
    ifa.s_valid_i = 1'b0;
    a_drain();
    check("t2_out0", out_a[0] - base0, 2);
    check("t2_out1", out_a[1] - base1, 1);

    // Backpressure on output 0: only two beats fit, then ready drops.
    base0 = out_a[0];
    ifa.m_ready_i = 2'b10;
    a_send(0, 8'hD1, 0);
    a_send(0, 8'hD2, 0);
    a_drive(0, 8'hD3, 0);
    repeat (3) begin
      @(negedge clk);
      check("t3_full_ready", 32'(ifa.s_ready_o), 0);
      check("t3_hold_valid", 32'(ifa.m_valid_o), 1);
      check("t3_hold_data", 32'(ifa.m_data_o[0]), 32'h D1);
    end
    @(posedge clk); #1; ifa.m_ready_i = 2'b11;
    a_send(0, 8'hD3, 0);
    a_send(0, 8'hD4, 1);
    ifa.s_valid_i = 1'b0;
    a_drain();
    check("t3_out0", out_a[0] - base0, 4);
    check("a_drops_model", 32'(drop_a), drops_a);
    check("a_drops_lit", 32'(drop_a), 0);

    // Drop on N=3: id=3 packet vanishes, id=2 packet exits on output 2.
    base0 = out_b[0]; base1 = out_b[1]; base2 = out_b[2];
    ifb.m_ready_i = 3'b111;
    b_send(3, 8'hE1, 0);
    b_send(3, 8'hE2, 1);
    b_send(2, 8'hF1, 1);
    ifb.s_valid_i = 1'b0;
    b_drain();
    check("t4_drop", 32'(drop_b), 1);
    check("t4_drop_model", 32'(drop_b), drops_b);
    check("t4_out2", out_b[2] - base2, 1);
    check("t4_out01", (out_b[0] - base0) + (out_b[1] - base1), 0);

    // Saturation of a 2-bit drop counter from a clean reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_cleared", 32'(drop_b), 0);
    for (int i = 0; i < 5; i++) begin
      b_send(3, 8'h50 + i, 1);
      ifb.s_valid_i = 1'b0;
      @(posedge clk); #1;
      check($sformatf("t5_sat%0d", i), 32'(drop_b), sat_exp[i]);
    end
    b_drain();
    check("t5_sat_model", 32'(drop_b), drops_b);
    check("t5_no_output", 32'(ifb.m_valid_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
